// File: rtl/seg_display_scanner.sv
// seg_display_scanner: time-multiplexed scan controller for a DIGITS-wide
// common-anode seven-segment display sharing one external nibble decoder.
// New values are latched tear-free: they are shown only from a frame boundary.
//
// Ports:
//   clock       system clock, rising edge
//   clear_n     synchronous active-low reset
//   enable      scan enable; low freezes the scan and blanks the display
//   value       hex value to show; nibble k drives digit k
//   load        one-cycle strobe capturing value into the pending register
//   nibble      nibble for the shared seven_segment_decoder
//   an          active-low digit enables
//   digit_idx   currently scanned digit
//   frame_done  one-cycle pulse in the first cycle of each frame
//   load_ack    one-cycle pulse when a pending value becomes displayed
//
// Optional feature macro: LEADING_ZERO_BLANK_EN
//   When defined, digits above the most significant non-zero nibble stay
//   dark; digit 0 always follows the normal rule.
module seg_display_scanner #(
    parameter int unsigned DIGITS       = 8,
    parameter int unsigned IDX_W        = 3,
    parameter int unsigned REFRESH_DIV  = 50000,
    parameter int unsigned CNT_W        = 16,
    parameter int unsigned BLANK_CYCLES = 2
) (
    input  logic                  clock,
    input  logic                  clear_n,
    input  logic                  enable,
    input  logic [4*DIGITS-1:0]   value,
    input  logic                  load,
    output logic [3:0]            nibble,
    output logic [DIGITS-1:0]     an,
    output logic [IDX_W-1:0]      digit_idx,
    output logic                  frame_done,
    output logic                  load_ack
);

    localparam int unsigned      VAL_W     = 4 * DIGITS;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYCLES);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DIGITS - 1);

    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [IDX_W-1:0] idx_nxt;
    logic [VAL_W-1:0] disp, disp_nxt;
    logic [VAL_W-1:0] pend, pend_nxt;
    logic             pend_valid, pend_valid_nxt;
    logic             frame_done_nxt, load_ack_nxt;
    logic             tick, wrap;
    logic [DIGITS-1:0] lz_blank;

    // Slot tick at the end of each prescaler period; wrap on the last digit's tick.
    assign tick = enable && (cnt == CNT_LAST);
    assign wrap = tick && (digit_idx == IDX_LAST);

    // Next-state logic: scan counters, tear-free display latch, status pulses.
    always_comb begin
        cnt_nxt        = cnt;
        idx_nxt        = digit_idx;
        disp_nxt       = disp;
        pend_nxt       = pend;
        pend_valid_nxt = pend_valid;
        frame_done_nxt = wrap;
        load_ack_nxt   = wrap && (pend_valid || load);

        if (enable) begin
            cnt_nxt = tick ? '0 : cnt + CNT_W'(1);
            if (tick) begin
                idx_nxt = (digit_idx == IDX_LAST) ? '0 : digit_idx + IDX_W'(1);
            end
        end

        if (wrap) begin
            // A load coinciding with the wrap bypasses the pending register.
            if (load) begin
                disp_nxt = value;
            end else if (pend_valid) begin
                disp_nxt = pend;
            end
            pend_valid_nxt = 1'b0;
        end else if (load) begin
            pend_nxt       = value;
            pend_valid_nxt = 1'b1;
        end
    end

    // State registers.
    always_ff @(posedge clock) begin
        if (!clear_n) begin
            cnt        <= '0;
            digit_idx  <= '0;
            disp       <= '0;
            pend       <= '0;
            pend_valid <= 1'b0;
            frame_done <= 1'b0;
            load_ack   <= 1'b0;
        end else begin
            cnt        <= cnt_nxt;
            digit_idx  <= idx_nxt;
            disp       <= disp_nxt;
            pend       <= pend_nxt;
            pend_valid <= pend_valid_nxt;
            frame_done <= frame_done_nxt;
            load_ack   <= load_ack_nxt;
        end
    end

    // Leading-zero mask: digit k is dark when nibbles k..DIGITS-1 are all zero.
    always_comb begin
        lz_blank = '0;
`ifdef LEADING_ZERO_BLANK_EN
        begin : g_lz
            logic zero_run;
            zero_run = 1'b1;
            for (int k = int'(DIGITS) - 1; k > 0; k--) begin
                zero_run    = zero_run && (disp[4*k +: 4] == 4'h0);
                lz_blank[k] = zero_run;
            end
        end
`endif
    end

    // Digit select and nibble mux; the first BLANK_CYCLES of a slot stay dark.
    always_comb begin
        an     = '1;
        nibble = 4'h0;
        for (int k = 0; k < int'(DIGITS); k++) begin
            if (digit_idx == IDX_W'(k)) begin
                nibble = disp[4*k +: 4];
                if (enable && (cnt >= CNT_BLANK) && !lz_blank[k]) begin
                    an[k] = 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_seg_display_scanner.sv
module tb_seg_display_scanner;

    localparam int D = 4;
    localparam int R = 4;
    localparam int B = 1;
    localparam int FRAME = D * R;

    logic        clock = 1'b0;
    logic        clear_n = 1'b0;
    logic        enable = 1'b0;
    logic [15:0] value = '0;
    logic        load = 1'b0;
    logic [3:0]  nibble;
    logic [3:0]  an;
    logic [1:0]  digit_idx;
    logic        frame_done;
    logic        load_ack;

    int tests_run = 0;
    int tests_failed = 0;

    // Reference model: position within the frame in enabled cycles.
    int          m_pos = 0;
    logic [15:0] m_disp = '0;
    logic [15:0] m_pend = '0;
    bit          m_pv = 0;
    bit          m_fd = 0;
    bit          m_la = 0;

    seg_display_scanner #(
        .DIGITS(D), .IDX_W(2), .REFRESH_DIV(R), .CNT_W(3), .BLANK_CYCLES(B)
    ) dut (
        .clock(clock), .clear_n(clear_n), .enable(enable), .value(value),
        .load(load), .nibble(nibble), .an(an), .digit_idx(digit_idx),
        .frame_done(frame_done), .load_ack(load_ack)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step(input bit c, input bit e, input bit l, input logic [15:0] v);
        bit wrap;
        if (!c) begin
            m_pos = 0; m_disp = '0; m_pend = '0; m_pv = 0; m_fd = 0; m_la = 0;
        end else begin
            wrap = e && (m_pos == FRAME - 1);
            m_fd = wrap;
            m_la = wrap && (m_pv || l);
            if (wrap) begin
                if (l) m_disp = v;
                else if (m_pv) m_disp = m_pend;
                m_pv = 0;
            end else if (l) begin
                m_pend = v;
                m_pv = 1;
            end
            if (e) m_pos = (m_pos + 1) % FRAME;
        end
    endtask

    function automatic logic [3:0] exp_an();
        logic [3:0] a;
        int idx;
        bit lit;
        a = 4'hF;
        idx = m_pos / R;
        if (enable && (m_pos % R) >= B) begin
            lit = 1;
`ifdef LEADING_ZERO_BLANK_EN
            if (idx > 0 && (m_disp >> (4 * idx)) == 16'h0) lit = 0;
`endif
            if (lit) a[idx] = 1'b0;
        end
        return a;
    endfunction

    task automatic check_outputs();
        logic [15:0] sh;
        sh = m_disp >> (4 * (m_pos / R));
        check("an", 32'(an), 32'(exp_an()));
        check("nibble", 32'(nibble), 32'(sh[3:0]));
        check("digit_idx", 32'(digit_idx), 32'(m_pos / R));
        check("frame_done", 32'(frame_done), 32'(m_fd));
        check("load_ack", 32'(load_ack), 32'(m_la));
    endtask

    task automatic step(input bit c, input bit e, input bit l, input logic [15:0] v);
        clear_n = c; enable = e; load = l; value = v;
        @(posedge clock);
        model_step(c, e, l, v);
        @(negedge clock);
        check_outputs();
    endtask

    // Advance with enable high until the model sits at the given frame position.
    task automatic run_to(input int target);
        int n;
        n = 0;
        while (m_pos != target && n < 100) begin
            step(1, 1, 0, '0);
            n++;
        end
        check("run_to_timeout", 32'(m_pos == target), 32'd1);
    endtask

    initial begin
        int last_fd;
        int fd_cycles;

        // Power-up reset
        repeat (3) step(0, 1, 0, '0);
        check("rst_an", 32'(an), 32'hF);
        check("rst_nibble", 32'(nibble), 32'h0);

        // Reset mid-scan with a pending value discards it
        run_to(5);
        step(1, 1, 1, 16'h9876);
        repeat (3) step(0, 1, 0, '0);
        check("rst2_idx", 32'(digit_idx), 32'h0);
        check("rst2_la", 32'(load_ack), 32'h0);
        repeat (FRAME + 2) step(1, 1, 0, '0);

        // Scan order and frame period
        step(1, 1, 1, 16'h1234);
        run_to(FRAME - 1);
        step(1, 1, 0, '0);
        check("scan_la", 32'(load_ack), 32'h1);
        check("scan_fd", 32'(frame_done), 32'h1);
        check("scan_nib0", 32'(nibble), 32'h4);
        last_fd = 0;
        fd_cycles = 0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            step(1, 1, 0, '0);
            fd_cycles++;
            if (frame_done) begin
                check("fd_period", 32'(fd_cycles), 32'(FRAME));
                fd_cycles = 0;
            end
        end

        // Mid-frame load shows only after the wrap
        run_to(2 * R);
        step(1, 1, 1, 16'hABCD);
        check("mid_nib_old", 32'(nibble), 32'h2);
        run_to(FRAME - 1);
        step(1, 1, 0, '0);
        check("mid_la", 32'(load_ack), 32'h1);
        check("mid_nib_new", 32'(nibble), 32'hD);

        // Overwrite: last load before the wrap wins
        run_to(3);
        step(1, 1, 1, 16'h1111);
        step(1, 1, 1, 16'h2222);
        run_to(0);
        check("ovw_nib", 32'(nibble), 32'h2);

        // Bypass: load on the exact wrap edge
        run_to(FRAME - 1);
        step(1, 1, 1, 16'h5555);
        check("byp_la", 32'(load_ack), 32'h1);
        check("byp_nib", 32'(nibble), 32'h5);

        // Enable freeze at idx 1, cnt 2
        run_to(R + 2);
        for (int i = 0; i < 10; i++) begin
            step(1, 0, 0, '0);
            check("frz_an", 32'(an), 32'hF);
            check("frz_fd", 32'(frame_done), 32'h0);
        end
        step(1, 1, 0, '0);
        check("frz_resume_idx", 32'(digit_idx), 32'h1);

        // Leading-zero values
        run_to(FRAME - 1);
        step(1, 1, 1, 16'h0050);
        repeat (FRAME) step(1, 1, 0, '0);
        run_to(FRAME - 1);
        step(1, 1, 1, 16'h0000);
        repeat (FRAME) step(1, 1, 0, '0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 299) != 0),
                 ($urandom_range(0, 9) != 0),
                 ($urandom_range(0, 19) == 0),
                 16'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
